// File: rtl/pingpong_bank_sched.sv
// Ping/pong BRAM bank scheduler: steers producer writes into the filling bank,
// drains full banks to a back-pressured consumer in fill order, counts dropped words.
module pingpong_bank_sched #(
  parameter int C_ADDR_WIDTH = 16,
  parameter int C_RD_LAT     = 2,
  parameter int C_OVF_WIDTH  = 16
) (
  input  logic                    I_clk,
  input  logic                    I_rst_n,
  input  logic                    I_enable,
  input  logic [C_ADDR_WIDTH:0]   I_cfgLen,
  input  logic                    I_wDataEn,
  output logic                    O_wEn,
  output logic                    O_wBank,
  output logic [C_ADDR_WIDTH-1:0] O_wAddr,
  input  logic                    I_rReady,
  output logic                    O_rAddrEn,
  output logic                    O_rBank,
  output logic [C_ADDR_WIDTH-1:0] O_rAddr,
  output logic                    O_rLast,
  output logic                    O_rDataEn,
  output logic                    O_rDataBank,
  output logic [1:0]              O_bankFull,
  output logic                    O_overflow,
  output logic [C_OVF_WIDTH-1:0]  O_ovfCnt
);

  typedef enum logic [1:0] {B_EMPTY, B_FILL, B_FULL, B_DRAIN} bankState_t;
  typedef enum logic {W_RUN, W_STALL} wState_t;
  typedef enum logic {R_IDLE, R_RUN} rState_t;

  localparam logic [C_ADDR_WIDTH:0] MAX_LEN = {1'b1, {C_ADDR_WIDTH{1'b0}}};

  bankState_t              bankStateReg [2];
  bankState_t              bankStateNext[2];
  logic [C_ADDR_WIDTH-1:0] lenM1Reg     [2];
  logic [C_ADDR_WIDTH-1:0] lenM1Next    [2];

  wState_t                 wStateReg, wStateNext;
  logic                    wBankReg, wBankNext;
  logic [C_ADDR_WIDTH-1:0] wCntReg, wCntNext;
  rState_t                 rStateReg, rStateNext;
  logic                    rBankReg, rBankNext;
  logic [C_ADDR_WIDTH-1:0] rCntReg, rCntNext;

  logic                    wEnReg, wEnNext;
  logic                    wBankOutReg, wBankOutNext;
  logic [C_ADDR_WIDTH-1:0] wAddrReg, wAddrNext;
  logic                    rAddrEnReg, rAddrEnNext;
  logic                    rBankOutReg, rBankOutNext;
  logic [C_ADDR_WIDTH-1:0] rAddrReg, rAddrNext;
  logic                    rLastReg, rLastNext;
  logic                    overflowReg, overflowNext;
  logic [C_OVF_WIDTH-1:0]  ovfCntReg, ovfCntNext;

  logic                    wOther;
  logic [C_ADDR_WIDTH-1:0] cfgLenM1;
  logic [C_ADDR_WIDTH-1:0] curLenM1;
  logic                    wFire, rFire, drainDone;

  assign wOther = ~wBankReg;

  // Out-of-range or zero length means a full-depth frame; the low bits wrap to all-ones then.
  always_comb begin
    if (I_cfgLen > MAX_LEN) cfgLenM1 = '1;
    else                    cfgLenM1 = I_cfgLen[C_ADDR_WIDTH-1:0] - C_ADDR_WIDTH'(1);
  end

  always_comb begin
    for (int b = 0; b < 2; b++) begin
      bankStateNext[b] = bankStateReg[b];
      lenM1Next[b]     = lenM1Reg[b];
    end
    wStateNext   = wStateReg;
    wBankNext    = wBankReg;
    wCntNext     = wCntReg;
    wEnNext      = 1'b0;
    wAddrNext    = wAddrReg;
    wFire        = 1'b0;
    curLenM1     = lenM1Reg[wBankReg];
    rStateNext   = rStateReg;
    rBankNext    = rBankReg;
    rCntNext     = rCntReg;
    rAddrEnNext  = 1'b0;
    rAddrNext    = rAddrReg;
    rLastNext    = 1'b0;
    rFire        = 1'b0;
    drainDone    = 1'b0;
    overflowNext = overflowReg;
    ovfCntNext   = ovfCntReg;

    case (rStateReg)
      R_IDLE: begin
        if (bankStateReg[rBankReg] == B_FULL) begin
          bankStateNext[rBankReg] = B_DRAIN;
          rStateNext              = R_RUN;
          rCntNext                = '0;
        end
      end
      R_RUN: begin
        if (I_rReady) begin
          rFire       = 1'b1;
          rAddrEnNext = 1'b1;
          rAddrNext   = rCntReg;
          rCntNext    = rCntReg + C_ADDR_WIDTH'(1);
          if (rCntReg == lenM1Reg[rBankReg]) begin
            rLastNext               = 1'b1;
            drainDone               = 1'b1;
            bankStateNext[rBankReg] = B_EMPTY;
            rBankNext               = ~rBankReg;
            rStateNext              = R_IDLE;
          end
        end
      end
      default: ;
    endcase

    // Write side runs after the read side so a same-edge DRAIN->FILL handoff overrides EMPTY.
    case (wStateReg)
      W_RUN: begin
        if (I_wDataEn) begin
          if (bankStateReg[wBankReg] == B_EMPTY) begin
            bankStateNext[wBankReg] = B_FILL;
            lenM1Next[wBankReg]     = cfgLenM1;
            curLenM1                = cfgLenM1;
          end
          wFire     = 1'b1;
          wEnNext   = 1'b1;
          wAddrNext = wCntReg;
          wCntNext  = wCntReg + C_ADDR_WIDTH'(1);
          if (wCntReg == curLenM1) begin
            bankStateNext[wBankReg] = B_FULL;
            wCntNext                = '0;
            if (bankStateReg[wOther] == B_EMPTY ||
                (bankStateReg[wOther] == B_DRAIN && drainDone)) begin
              bankStateNext[wOther] = B_FILL;
              lenM1Next[wOther]     = cfgLenM1;
              wBankNext             = wOther;
            end else begin
              wStateNext = W_STALL;
            end
          end
        end
      end
      W_STALL: begin
        if (I_wDataEn) begin
          overflowNext = 1'b1;
          if (ovfCntReg != '1) ovfCntNext = ovfCntReg + C_OVF_WIDTH'(1);
        end
        if (bankStateReg[wOther] == B_EMPTY) begin
          bankStateNext[wOther] = B_FILL;
          lenM1Next[wOther]     = cfgLenM1;
          wBankNext             = wOther;
          wStateNext            = W_RUN;
          wCntNext              = '0;
        end
      end
      default: ;
    endcase

    wBankOutNext = wFire ? wBankReg : wBankNext;
    rBankOutNext = rFire ? rBankReg : rBankNext;
  end

  always_ff @(posedge I_clk) begin
    if (!I_rst_n || !I_enable) begin
      for (int b = 0; b < 2; b++) begin
        bankStateReg[b] <= B_EMPTY;
        lenM1Reg[b]     <= '0;
      end
      wStateReg   <= W_RUN;
      wBankReg    <= 1'b0;
      wCntReg     <= '0;
      rStateReg   <= R_IDLE;
      rBankReg    <= 1'b0;
      rCntReg     <= '0;
      wEnReg      <= 1'b0;
      wBankOutReg <= 1'b0;
      wAddrReg    <= '0;
      rAddrEnReg  <= 1'b0;
      rBankOutReg <= 1'b0;
      rAddrReg    <= '0;
      rLastReg    <= 1'b0;
    end else begin
      for (int b = 0; b < 2; b++) begin
        bankStateReg[b] <= bankStateNext[b];
        lenM1Reg[b]     <= lenM1Next[b];
      end
      wStateReg   <= wStateNext;
      wBankReg    <= wBankNext;
      wCntReg     <= wCntNext;
      rStateReg   <= rStateNext;
      rBankReg    <= rBankNext;
      rCntReg     <= rCntNext;
      wEnReg      <= wEnNext;
      wBankOutReg <= wBankOutNext;
      wAddrReg    <= wAddrNext;
      rAddrEnReg  <= rAddrEnNext;
      rBankOutReg <= rBankOutNext;
      rAddrReg    <= rAddrNext;
      rLastReg    <= rLastNext;
    end
  end

  // Drop statistics survive a flush; only reset clears them.
  always_ff @(posedge I_clk) begin
    if (!I_rst_n) begin
      overflowReg <= 1'b0;
      ovfCntReg   <= '0;
    end else if (I_enable) begin
      overflowReg <= overflowNext;
      ovfCntReg   <= ovfCntNext;
    end
  end

  for (genvar gi = 0; gi < C_RD_LAT; gi++) begin : gRdLat
    logic enStage, bankStage, enIn, bankIn;
    if (gi == 0) begin : gSrc
      assign enIn   = rAddrEnReg;
      assign bankIn = rBankOutReg;
    end else begin : gSrc
      assign enIn   = gRdLat[gi-1].enStage;
      assign bankIn = gRdLat[gi-1].bankStage;
    end
    always_ff @(posedge I_clk) begin
      if (!I_rst_n || !I_enable) begin
        enStage   <= 1'b0;
        bankStage <= 1'b0;
      end else begin
        enStage   <= enIn;
        bankStage <= bankIn;
      end
    end
  end

  for (genvar gi = 0; gi < 2; gi++) begin : gBankFull
    assign O_bankFull[gi] = (bankStateReg[gi] == B_FULL) || (bankStateReg[gi] == B_DRAIN);
  end

  assign O_wEn       = wEnReg;
  assign O_wBank     = wBankOutReg;
  assign O_wAddr     = wAddrReg;
  assign O_rAddrEn   = rAddrEnReg;
  assign O_rBank     = rBankOutReg;
  assign O_rAddr     = rAddrReg;
  assign O_rLast     = rLastReg;
  assign O_rDataEn   = gRdLat[C_RD_LAT-1].enStage;
  assign O_rDataBank = gRdLat[C_RD_LAT-1].bankStage;
  assign O_overflow  = overflowReg;
  assign O_ovfCnt    = ovfCntReg;

endmodule

// File: tb/tb_pingpong_bank_sched.sv
// Randomized bench for pingpong_bank_sched against a frame-queue model of the
// ping/pong buffer (frames held in fill order, one filling, drops while both banks busy).
module tb_pingpong_bank_sched;

  localparam int AW     = 6;
  localparam int RDLAT  = 2;
  localparam int OVFW   = 4;
  localparam int MAXLEN = 1 << AW;
  localparam int OVFMAX = (1 << OVFW) - 1;

  logic            clk = 1'b0;
  logic            rstN, enable, wDataEn, rReady;
  logic [AW:0]     cfgLen;
  logic            wEn, wBank, rAddrEn, rBank, rLast, rDataEn, rDataBank, overflow;
  logic [AW-1:0]   wAddr, rAddr;
  logic [1:0]      bankFull;
  logic [OVFW-1:0] ovfCnt;

  pingpong_bank_sched #(.C_ADDR_WIDTH(AW), .C_RD_LAT(RDLAT), .C_OVF_WIDTH(OVFW)) dut (
    .I_clk(clk), .I_rst_n(rstN), .I_enable(enable), .I_cfgLen(cfgLen), .I_wDataEn(wDataEn),
    .O_wEn(wEn), .O_wBank(wBank), .O_wAddr(wAddr), .I_rReady(rReady),
    .O_rAddrEn(rAddrEn), .O_rBank(rBank), .O_rAddr(rAddr), .O_rLast(rLast),
    .O_rDataEn(rDataEn), .O_rDataBank(rDataBank), .O_bankFull(bankFull),
    .O_overflow(overflow), .O_ovfCnt(ovfCnt)
  );

  always #5 clk = ~clk;

  int nTests = 0;
  int nFail  = 0;
  int cycle  = 0;
  bit primed = 1'b0;

  // Full frames (FULL or being drained) in the order they were filled.
  typedef struct { int bank; int len; } frame_t;
  frame_t heldQ[$];

  int  fillMode;   // 0 = no frame yet, 1 = accepting words, 2 = both banks busy
  int  fillBank, fillLen, fillCnt, rdBank, drainCnt, drops;
  bit  drainActive, ovfSeen;
  bit  eWEn, eWBank, eRAddrEn, eRBank, eRLast;
  bit  [AW-1:0] eWAddr, eRAddr;
  bit  pipeEn[RDLAT];
  bit  pipeBank[RDLAT];

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nTests++;
    if (got !== exp) begin
      nFail++;
      $display("FAIL %s cycle %0d: got 0x%0h, expected 0x%0h", tag, cycle, got, exp);
    end
  endtask

  function automatic int effLen(input int c);
    return (c == 0 || c > MAXLEN) ? MAXLEN : c;
  endfunction

  task automatic modelStep(input bit rN, input bit en, input int cfg, input bit w, input bit r);
    int heldBefore, len;
    bit drainEnds, startDrain, wrote;
    if (!rN || !en) begin
      heldQ.delete();
      fillMode = 0; fillBank = 0; fillLen = 0; fillCnt = 0;
      rdBank = 0; drainCnt = 0; drainActive = 1'b0;
      eWEn = 1'b0; eWBank = 1'b0; eWAddr = '0;
      eRAddrEn = 1'b0; eRBank = 1'b0; eRLast = 1'b0; eRAddr = '0;
      for (int i = 0; i < RDLAT; i++) begin pipeEn[i] = 1'b0; pipeBank[i] = 1'b0; end
      if (!rN) begin drops = 0; ovfSeen = 1'b0; end
      return;
    end
    for (int i = RDLAT - 1; i > 0; i--) begin pipeEn[i] = pipeEn[i-1]; pipeBank[i] = pipeBank[i-1]; end
    pipeEn[0]   = eRAddrEn;
    pipeBank[0] = eRBank;

    len        = effLen(cfg);
    heldBefore = heldQ.size();
    drainEnds  = 1'b0;
    if (drainActive && r) drainEnds = (drainCnt == heldQ[0].len - 1);
    startDrain = !drainActive && heldBefore > 0;

    // Consumer side
    eRAddrEn = 1'b0;
    eRLast   = 1'b0;
    if (drainActive && r) begin
      eRAddrEn = 1'b1;
      eRAddr   = AW'(drainCnt);
      eRBank   = (heldQ[0].bank != 0);
      if (drainEnds) begin
        eRLast = 1'b1;
        void'(heldQ.pop_front());
        drainActive = 1'b0;
        rdBank ^= 1;
      end else begin
        drainCnt++;
      end
    end else begin
      eRBank = (rdBank != 0);
      if (startDrain) begin drainActive = 1'b1; drainCnt = 0; end
    end

    // Producer side
    wrote = 1'b0;
    eWEn  = 1'b0;
    if (fillMode == 0 && w) begin fillMode = 1; fillLen = len; fillCnt = 0; end
    if (fillMode == 1) begin
      if (w) begin
        wrote  = 1'b1;
        eWEn   = 1'b1;
        eWAddr = AW'(fillCnt);
        eWBank = (fillBank != 0);
        fillCnt++;
        if (fillCnt == fillLen) begin
          heldQ.push_back('{fillBank, fillLen});
          if (heldBefore == 0 || (heldBefore == 1 && drainEnds)) begin
            fillBank ^= 1; fillLen = len; fillCnt = 0;
          end else begin
            fillMode = 2;
          end
        end
      end
    end else if (fillMode == 2) begin
      if (w) begin ovfSeen = 1'b1; if (drops < OVFMAX) drops++; end
      if (heldBefore <= 1) begin fillBank ^= 1; fillLen = len; fillCnt = 0; fillMode = 1; end
    end
    if (!wrote) eWBank = (fillBank != 0);
  endtask

  task automatic compareAll();
    bit [1:0] expFull;
    expFull = '0;
    foreach (heldQ[i]) expFull[heldQ[i].bank] = 1'b1;
    checkVal("write", {wEn, wBank, wAddr}, {eWEn, eWBank, eWAddr});
    checkVal("read", {rAddrEn, rBank, rLast, rAddr}, {eRAddrEn, eRBank, eRLast, eRAddr});
    checkVal("rdata", {rDataEn, rDataBank}, {pipeEn[RDLAT-1], pipeBank[RDLAT-1]});
    checkVal("bankFull", bankFull, expFull);
    checkVal("ovf", {overflow, ovfCnt}, {ovfSeen, OVFW'(drops)});
    if (rAddrEn && rLast)
      $display("[TB] cycle %0d: frame read done, bank %0d, last addr %0d, dropped %0d",
               cycle, rBank, rAddr, ovfCnt);
  endtask

  task automatic runCycle(input bit rN, input bit en, input int cfg, input bit w, input bit r);
    @(negedge clk);
    if (primed) compareAll();
    rstN    = rN;
    enable  = en;
    cfgLen  = cfg[AW:0];
    wDataEn = w;
    rReady  = r;
    modelStep(rN, en, cfg, w, r);
    primed = 1'b1;
    cycle++;
  endtask

  // start: 0 none, 1 reset, 2 flush; rst/flush rates are per mille
  typedef struct { int start; int cycles; int wPct; int rPct; int lenLo; int lenHi; int rstPm; int flushPm; } phase_t;
  phase_t ph[9];

  initial begin
    rstN = 1'b0; enable = 1'b1; wDataEn = 1'b0; rReady = 1'b0; cfgLen = '0;
    ph[0] = '{1,   40, 100, 100,  4,   4, 0,  0};  // back-to-back frames
    ph[1] = '{1,   30, 100,   0,  4,   4, 0,  0};  // both banks full, drops saturate
    ph[2] = '{2,   60, 100,  50,  8,   8, 0,  0};  // flush keeps drop count; gappy ready
    ph[3] = '{0,  300, 100, 100,  0,   0, 0,  0};  // zero length -> full depth
    ph[4] = '{0,  250,  80,  90, 65, 127, 0,  0};  // oversize length -> full depth
    ph[5] = '{1,  120, 100, 100,  3,   5, 0,  0};  // length changing every cycle
    ph[6] = '{0, 2000,  60,  60,  1,   9, 5, 10};
    ph[7] = '{2, 1000,  90,  30,  1,   5, 3,  8};
    ph[8] = '{1,  800,  30,  95,  1,  12, 0,  5};

    runCycle(1'b0, 1'b1, 4, 1'b0, 1'b0);
    runCycle(1'b0, 1'b1, 4, 1'b0, 1'b0);
    for (int p = 0; p < 9; p++) begin
      if (ph[p].start == 1) runCycle(1'b0, 1'b1, ph[p].lenLo, 1'b1, 1'b1);
      if (ph[p].start == 2) runCycle(1'b1, 1'b0, ph[p].lenLo, 1'b1, 1'b1);
      for (int c = 0; c < ph[p].cycles; c++) begin
        bit rN, en, w, r;
        int cfg;
        rN  = !($urandom_range(999) < ph[p].rstPm);
        en  = !($urandom_range(999) < ph[p].flushPm);
        w   = ($urandom_range(99) < ph[p].wPct);
        r   = ($urandom_range(99) < ph[p].rPct);
        cfg = $urandom_range(ph[p].lenHi, ph[p].lenLo);
        runCycle(rN, en, cfg, w, r);
      end
    end
    @(negedge clk);
    compareAll();
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
